// File: rtl/glitch_pulse_gen_if.sv
// Command/pin bundle between the UART command parser and the glitch pulse generator.
// The parser side (master) drives configuration and strobes; the generator (slave) drives the pin outputs.
interface glitch_pulse_gen_if #(
    parameter int DELAY_W = 32,
    parameter int WIDTH_W = 16
) ();
    logic [DELAY_W-1:0] cfg_delay;
    logic [WIDTH_W-1:0] cfg_width;
    logic               arm;
    logic               disarm;
    logic               trigger_in;
    logic               pulse_out;
    logic               pulse_en;
    logic               armed;
    logic               done;
    logic [7:0]         pulse_count;

    modport master (
        output cfg_delay,
        output cfg_width,
        output arm,
        output disarm,
        output trigger_in,
        input  pulse_out,
        input  pulse_en,
        input  armed,
        input  done,
        input  pulse_count
    );

    modport slave (
        input  cfg_delay,
        input  cfg_width,
        input  arm,
        input  disarm,
        input  trigger_in,
        output pulse_out,
        output pulse_en,
        output armed,
        output done,
        output pulse_count
    );
endinterface

// File: rtl/glitch_pulse_gen.sv
// One-shot glitch pulse generator: after arming, waits for a synchronized trigger rising edge,
// then drives pulse_out high for W cycles starting D cycles after the edge.
module glitch_pulse_gen #(
    parameter int DELAY_W = 32,
    parameter int WIDTH_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    glitch_pulse_gen_if.slave  bus
);

    localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2,
        ST_PULSE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DELAY_W-1:0] r_delay;
    logic [DELAY_W-1:0] w_delay_nxt;
    logic [WIDTH_W-1:0] r_width;
    logic [WIDTH_W-1:0] w_width_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [7:0]         r_count;
    logic [7:0]         w_count_nxt;
    logic               w_done_nxt;

    logic               r_s1;
    logic               r_s2;
    logic               r_s3;
    logic               w_rise;

    logic               r_pulse_out;
    logic               r_pulse_en;
    logic               r_armed;
    logic               r_done;

    logic [CNT_W-1:0]   w_delay_m1;
    logic [CNT_W-1:0]   w_width_m1;

    // Trigger synchronizer (s1, s2) plus history flop s3 for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.trigger_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    // Counter reload values; the counter holds "cycles remaining minus one", so it never underflows.
    assign w_delay_m1 = CNT_W'(r_delay) - CNT_W'(1'b1);
    assign w_width_m1 = CNT_W'(r_width) - CNT_W'(1'b1);

    // Next-state, counter and latch logic; disarm outranks rise and counter expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_delay_nxt = r_delay;
        w_width_nxt = r_width;
        w_cnt_nxt   = r_cnt;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.arm && (bus.cfg_width != {WIDTH_W{1'b0}})) begin
                    w_delay_nxt = bus.cfg_delay;
                    w_width_nxt = bus.cfg_width;
                    w_state_nxt = ST_ARMED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (bus.disarm) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rise) begin
                    if (r_delay == {DELAY_W{1'b0}}) begin
                        w_state_nxt = ST_PULSE;
                        w_cnt_nxt   = w_width_m1;
                    end else begin
                        w_state_nxt = ST_DELAY;
                        w_cnt_nxt   = w_delay_m1;
                    end
                end else begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_DELAY: begin
                if (bus.disarm) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = w_width_m1;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1'b1);
                end
            end
            ST_PULSE: begin
                if (bus.disarm) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_count_nxt = r_count + 8'd1;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1'b1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, latched configuration and counters; outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_delay     <= {DELAY_W{1'b0}};
            r_width     <= {WIDTH_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_count     <= 8'd0;
            r_pulse_out <= 1'b0;
            r_pulse_en  <= 1'b0;
            r_armed     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_delay     <= w_delay_nxt;
            r_width     <= w_width_nxt;
            r_cnt       <= w_cnt_nxt;
            r_count     <= w_count_nxt;
            r_pulse_out <= (w_state_nxt == ST_PULSE);
            r_pulse_en  <= (w_state_nxt != ST_IDLE);
            r_armed     <= (w_state_nxt == ST_ARMED);
            r_done      <= w_done_nxt;
        end
    end

    assign bus.pulse_out   = r_pulse_out;
    assign bus.pulse_en    = r_pulse_en;
    assign bus.armed       = r_armed;
    assign bus.done        = r_done;
    assign bus.pulse_count = r_count;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Directed bench for glitch_pulse_gen: pulse timing, zero-width arm, aborts, ignored events,
// counter wrap and reset during a pulse.
module tb_glitch_pulse_gen;

    logic clk;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;
    logic [3:0] w_vec;
    int   base;

    glitch_pulse_gen_if #(.DELAY_W(32), .WIDTH_W(16)) bus ();

    glitch_pulse_gen #(.DELAY_W(32), .WIDTH_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {pulse_out, armed, done, pulse_en}
    assign w_vec = {bus.pulse_out, bus.armed, bus.done, bus.pulse_en};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Expected output vector j edges after the trigger is first sampled high.
    function automatic logic [3:0] exp_vec(input int j, input int d, input int w);
        logic po;
        logic ar;
        logic dn;
        logic en;
        po = (j >= d + 2) && (j < d + 2 + w);
        ar = (j < 2);
        dn = (j == d + 2 + w);
        en = (j < d + 2 + w);
        return {po, ar, dn, en};
    endfunction

    task automatic arm_gen(input logic [31:0] d, input logic [15:0] w);
        bus.cfg_delay = d;
        bus.cfg_width = w;
        bus.arm       = 1'b1;
        step(1);
        bus.arm       = 1'b0;
    endtask

    // Raise the trigger (already armed, trigger previously sampled low) and check every cycle.
    // mode 1: extra trigger edge during DELAY; mode 2: arm with new config during DELAY.
    task automatic run_pulse(input string tag, input int d, input int w, input int mode);
        bus.trigger_in = 1'b1;
        step(1);
        check($sformatf("%s j=0", tag), {28'd0, w_vec}, {28'd0, exp_vec(0, d, w)});
        for (int j = 1; j <= d + w + 3; j++) begin
            if (mode == 1 && j == 1) bus.trigger_in = 1'b0;
            if (mode == 1 && j == 3) bus.trigger_in = 1'b1;
            if (mode == 2 && j == 3) begin
                bus.cfg_delay = 32'd0;
                bus.cfg_width = 16'd7;
                bus.arm       = 1'b1;
            end
            if (mode == 2 && j == 4) bus.arm = 1'b0;
            step(1);
            check($sformatf("%s j=%0d", tag, j), {28'd0, w_vec}, {28'd0, exp_vec(j, d, w)});
        end
        bus.trigger_in = 1'b0;
        step(3);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.cfg_delay  = 32'd0;
        bus.cfg_width  = 16'd0;
        bus.arm        = 1'b0;
        bus.disarm     = 1'b0;
        bus.trigger_in = 1'b0;
        step(2);
        check("reset_outs", {28'd0, w_vec}, 32'd0);
        check("reset_count", {24'd0, bus.pulse_count}, 32'd0);
        rst_n = 1'b1;
        step(1);

        // Basic pulse D=5, W=3
        arm_gen(32'd5, 16'd3);
        check("basic_armed", {28'd0, w_vec}, 32'h5);
        run_pulse("basic", 5, 3, 0);
        check("basic_count", {24'd0, bus.pulse_count}, 32'd1);

        // Zero delay, minimum width
        arm_gen(32'd0, 16'd1);
        run_pulse("d0w1", 0, 1, 0);
        check("d0w1_count", {24'd0, bus.pulse_count}, 32'd2);

        // Width zero: arm ignored, trigger does nothing
        arm_gen(32'd5, 16'd0);
        check("w0_armed", {28'd0, w_vec}, 32'd0);
        bus.trigger_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            check($sformatf("w0_idle i=%0d", i), {28'd0, w_vec}, 32'd0);
        end
        bus.trigger_in = 1'b0;
        step(3);
        check("w0_count", {24'd0, bus.pulse_count}, 32'd2);

        // Abort during DELAY
        arm_gen(32'd100, 16'd10);
        bus.trigger_in = 1'b1;
        step(1);
        step(49);
        check("abort_d_pre", {28'd0, w_vec}, 32'h1);
        bus.disarm = 1'b1;
        step(1);
        bus.disarm = 1'b0;
        check("abort_d_edge", {28'd0, w_vec}, 32'd0);
        for (int i = 0; i < 120; i++) begin
            step(1);
            check($sformatf("abort_d_after i=%0d", i), {28'd0, w_vec}, 32'd0);
        end
        bus.trigger_in = 1'b0;
        step(3);
        check("abort_d_count", {24'd0, bus.pulse_count}, 32'd2);

        // Abort three cycles into PULSE
        arm_gen(32'd2, 16'd10);
        bus.trigger_in = 1'b1;
        step(1);
        step(6);
        check("abort_p_high", {28'd0, w_vec}, 32'h9);
        bus.disarm = 1'b1;
        step(1);
        bus.disarm = 1'b0;
        check("abort_p_edge", {28'd0, w_vec}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            step(1);
            check($sformatf("abort_p_after i=%0d", i), {28'd0, w_vec}, 32'd0);
        end
        bus.trigger_in = 1'b0;
        step(3);
        check("abort_p_count", {24'd0, bus.pulse_count}, 32'd2);

        // Second trigger edge during DELAY
        arm_gen(32'd6, 16'd2);
        run_pulse("retrig", 6, 2, 1);
        check("retrig_count", {24'd0, bus.pulse_count}, 32'd3);

        // New arm during DELAY
        arm_gen(32'd6, 16'd2);
        run_pulse("rearm", 6, 2, 2);
        check("rearm_count", {24'd0, bus.pulse_count}, 32'd4);

        // Trigger held high before arming
        bus.trigger_in = 1'b1;
        step(4);
        arm_gen(32'd1, 16'd1);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check($sformatf("held_hi i=%0d", i), {28'd0, w_vec}, 32'h5);
        end
        bus.trigger_in = 1'b0;
        step(1);
        run_pulse("held_relaunch", 1, 1, 0);
        check("held_count", {24'd0, bus.pulse_count}, 32'd5);

        // 256 complete cycles wrap the counter back to its start value
        base = 5;
        for (int i = 0; i < 256; i++) begin
            bus.trigger_in = 1'b0;
            bus.cfg_delay  = 32'd0;
            bus.cfg_width  = 16'd1;
            bus.arm        = 1'b1;
            step(1);
            bus.arm        = 1'b0;
            bus.trigger_in = 1'b1;
            step(1);
            step(4);
            if (i == 250) check("wrap_zero", {24'd0, bus.pulse_count}, 32'd0);
        end
        bus.trigger_in = 1'b0;
        step(3);
        check("wrap_full", {24'd0, bus.pulse_count}, 32'(base));

        // Reset mid-pulse
        arm_gen(32'd2, 16'd10);
        bus.trigger_in = 1'b1;
        step(1);
        step(6);
        check("rst_p_high", {28'd0, w_vec}, 32'h9);
        rst_n = 1'b0;
        step(1);
        check("rst_p_outs", {28'd0, w_vec}, 32'd0);
        check("rst_p_count", {24'd0, bus.pulse_count}, 32'd0);
        rst_n = 1'b1;
        step(3);
        check("rst_p_idle", {28'd0, w_vec}, 32'd0);
        bus.trigger_in = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
